// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer running in the reference-clock domain.
// It pulses the PLL areset and waits for lock. The core is held in reset through a
// stabilisation window before release. A lock timeout retries the areset up to
// MAX_RETRIES times and then declares failure. Losing lock while running restarts
// the whole sequence.
module pll_reset_sequencer #(
  parameter int AR_CYCLES     = 16,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 3
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_locked,
  input  logic       i_restart,
  output logic       o_pll_areset,
  output logic       o_rst,
  output logic       o_fail,
  output logic       o_lock_lost,
  output logic [7:0] o_retries
);

  localparam int MAX_AS  = (AR_CYCLES > STABLE_CYCLES) ? AR_CYCLES : STABLE_CYCLES;
  localparam int MAX_CNT = (LOCK_TIMEOUT > MAX_AS) ? LOCK_TIMEOUT : MAX_AS;
  localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

  localparam logic [CNT_W-1:0] AR_LAST     = CNT_W'(AR_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [7:0]       RETRY_MAX   = 8'(MAX_RETRIES);

  typedef enum logic [2:0] {
    ST_ARST   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_STABLE = 3'd2,
    ST_RUN    = 3'd3,
    ST_FAIL   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       retries_d;
  logic             lock_lost_d;
  logic             locked_p0, locked_p1;

  // Two-flop synchroniser for the asynchronous PLL lock flag; locked_p1 is the only consumer view
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      locked_p0 <= 1'b0;
      locked_p1 <= 1'b0;
    end else begin
      locked_p0 <= i_locked;
      locked_p1 <= locked_p0;
    end
  end

  // Next-state, shared counter and retry/lock-lost bookkeeping
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CNT_W'(1);
    retries_d   = o_retries;
    lock_lost_d = o_lock_lost;
    case (state_q)
      ST_ARST: begin
        if (cnt_q == AR_LAST) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end
      end
      ST_WAIT: begin
        // Lock wins over a timeout landing in the same cycle
        if (locked_p1) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == LOCK_LAST) begin
          cnt_d = '0;
          if (o_retries == RETRY_MAX) begin
            state_d = ST_FAIL;
          end else begin
            state_d   = ST_ARST;
            retries_d = o_retries + 8'd1;
          end
        end
      end
      ST_STABLE: begin
        // A lock glitch restarts the timeout without spending a retry
        if (!locked_p1) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        cnt_d = '0;
        if (!locked_p1) begin
          state_d     = ST_ARST;
          lock_lost_d = 1'b1;
          retries_d   = 8'd0;
        end
      end
      ST_FAIL: begin
        cnt_d = '0;
      end
      default: begin
        state_d = ST_ARST;
        cnt_d   = '0;
      end
    endcase
    // Restart overrides every state but leaves a lock-lost flag raised this cycle intact
    if (i_restart) begin
      state_d   = ST_ARST;
      cnt_d     = '0;
      retries_d = 8'd0;
    end
  end

  // State register with outputs registered from the next state
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= ST_ARST;
      cnt_q        <= '0;
      o_pll_areset <= 1'b1;
      o_rst        <= 1'b1;
      o_fail       <= 1'b0;
      o_lock_lost  <= 1'b0;
      o_retries    <= 8'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      o_pll_areset <= (state_d == ST_ARST) || (state_d == ST_FAIL);
      o_rst        <= (state_d != ST_RUN);
      o_fail       <= (state_d == ST_FAIL);
      o_lock_lost  <= lock_lost_d;
      o_retries    <= retries_d;
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: a behavioural model feeds a per-cycle scoreboard,
// plus directed timing checks around reset, lock, glitch, loss, failure and restart.
module tb_pll_reset_sequencer;

  localparam int AR = 4;
  localparam int LT = 32;
  localparam int SC = 8;
  localparam int MR = 2;

  localparam int P_ARST = 0, P_WAIT = 1, P_STABLE = 2, P_RUN = 3, P_FAIL = 4;

  logic       clk = 1'b0;
  logic       rst, locked, restart;
  logic       o_pll_areset, o_rst, o_fail, o_lock_lost;
  logic [7:0] o_retries;
  logic [11:0] dut_vec;

  int n_vec  = 0;
  int n_miss = 0;

  // model state
  int m_ph, m_left, m_ret;
  bit m_lost, m_s1, m_s2;
  logic [11:0] exp_q[$];

  pll_reset_sequencer #(
    .AR_CYCLES(AR), .LOCK_TIMEOUT(LT), .STABLE_CYCLES(SC), .MAX_RETRIES(MR)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_locked(locked), .i_restart(restart),
    .o_pll_areset(o_pll_areset), .o_rst(o_rst), .o_fail(o_fail),
    .o_lock_lost(o_lock_lost), .o_retries(o_retries)
  );

  assign dut_vec = {o_pll_areset, o_rst, o_fail, o_lock_lost, o_retries};

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model of one clock edge, using countdown timers per phase
  task automatic model_edge();
    bit ls;
    if (rst) begin
      m_ph = P_ARST; m_left = AR; m_ret = 0; m_lost = 0; m_s1 = 0; m_s2 = 0;
    end else begin
      ls   = m_s2;
      m_s2 = m_s1;
      m_s1 = locked;
      case (m_ph)
        P_ARST: begin
          m_left--;
          if (m_left == 0) begin m_ph = P_WAIT; m_left = LT; end
        end
        P_WAIT: begin
          if (ls) begin
            m_ph = P_STABLE; m_left = SC;
          end else begin
            m_left--;
            if (m_left == 0) begin
              if (m_ret == MR) m_ph = P_FAIL;
              else begin m_ret++; m_ph = P_ARST; m_left = AR; end
            end
          end
        end
        P_STABLE: begin
          if (!ls) begin
            m_ph = P_WAIT; m_left = LT;
          end else begin
            m_left--;
            if (m_left == 0) m_ph = P_RUN;
          end
        end
        P_RUN: begin
          if (!ls) begin m_lost = 1; m_ret = 0; m_ph = P_ARST; m_left = AR; end
        end
        default: ;
      endcase
      if (restart) begin m_ph = P_ARST; m_left = AR; m_ret = 0; end
    end
    exp_q.push_back({(m_ph == P_ARST || m_ph == P_FAIL), (m_ph != P_RUN),
                     (m_ph == P_FAIL), m_lost, 8'(m_ret)});
  endtask

  task automatic cycle();
    logic [11:0] e;
    @(posedge clk);
    model_edge();
    #1;
    if (exp_q.size() == 0) begin
      check_val("sb_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check_val("sb", 32'(dut_vec), 32'(e));
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  int n;
  int falls;
  bit prev;

  initial begin
    rst = 1'b1; locked = 1'b0; restart = 1'b0;
    run(2);
    check_val("reset_state", 32'(dut_vec), 32'h0C00);

    // T1: release, areset lasts AR edges, lock raised before cycle 10
    rst = 1'b0;
    n = 0;
    do begin cycle(); n++; end while (o_pll_areset && n < 20);
    check_val("arst_len", n, AR);
    run(9 - n);
    locked = 1'b1;
    // 2 sync edges + WAIT->STABLE edge + SC STABLE cycles
    n = 0;
    do begin cycle(); n++; end while (o_rst && n < 60);
    check_val("lock_to_release", n, 3 + SC);
    check_val("t1_fail", o_fail, 0);
    check_val("t1_retries", o_retries, 0);

    // T5: lock drop in RUN
    run(5);
    locked = 1'b0;
    n = 0;
    do begin cycle(); n++; end while (!o_rst && n < 10);
    check_val("drop_to_rst", n, 3);
    check_val("lost_set", o_lock_lost, 1);
    run(2);
    locked = 1'b1;
    n = 0;
    do begin cycle(); n++; end while (o_rst && n < 60);
    check_val("relock_release", o_rst, 0);
    check_val("lost_sticky", o_lock_lost, 1);

    // T4: restart, then a one-cycle glitch while in STABLE
    restart = 1'b1;
    cycle();
    restart = 1'b0;
    run(4);
    locked = 1'b0;
    cycle();
    locked = 1'b1;
    n = 1;
    do begin cycle(); n++; end while (o_rst && n < 60);
    check_val("glitch_rerun", n, 12);
    check_val("glitch_retries", o_retries, 0);

    // T2: no lock at all -> three areset pulses, then FAIL
    rst = 1'b1; locked = 1'b0;
    cycle();
    rst = 1'b0;
    falls = 0; prev = 1'b1;
    for (int i = 0; i < 200; i++) begin
      cycle();
      if (prev && !o_pll_areset) falls++;
      prev = o_pll_areset;
    end
    check_val("arst_pulses", falls, MR + 1);
    check_val("fail_set", o_fail, 1);
    check_val("fail_areset", o_pll_areset, 1);
    check_val("fail_rst", o_rst, 1);
    check_val("fail_retries", o_retries, MR);

    // T3: restart out of FAIL with lock present
    locked = 1'b1;
    restart = 1'b1;
    cycle();
    restart = 1'b0;
    check_val("restart_fail_clr", o_fail, 0);
    check_val("restart_retries", o_retries, 0);
    n = 0;
    do begin cycle(); n++; end while (o_rst && n < 60);
    check_val("restart_release", o_rst, 0);

    // T6: i_rst with i_restart in WAIT_LOCK
    locked = 1'b0;
    run(3 + AR + 5);
    check_val("t6_lost", o_lock_lost, 1);
    rst = 1'b1; restart = 1'b1;
    cycle();
    check_val("rst_priority", 32'(dut_vec), 32'h0C00);
    rst = 1'b0; restart = 1'b0;
    run(6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
